clock_display_driver: RTL and testbench
=======================================

Name: clock_display_driver

Overview:
- Consumer end of the countdown-timer interface: takes `minute`, `second` and the timeout flag, and drives a 4-digit multiplexed seven-segment display showing M:SS.
- Sits between the per-player timer and the board's hex display pins.
- Converts binary to BCD, scans digits with a refresh prescaler, and blanks the display in a blinking pattern on timeout.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit (1 kHz digit rate at 100 MHz); must be >= 2.
- BLINK_DIV, 50000000: clk cycles per blink half-period; must be >= 2.
- SEG_ACTIVE_LOW, 1: 1 means segment and grid outputs are driven low to light; 0 means high to light.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  display enable (game screen active)
- minute  in  2  timer minutes, 0..3
- second  in  6  timer seconds, 0..59 valid
- to  in  1  timeout flag from timer
- hex_seg  out  8  segments {dp,g,f,e,d,c,b,a}
- hex_grid  out  4  digit selects; bit0 is the rightmost digit

Behaviour:
- Reset (reset=0, async):
  - Refresh counter = 0; digit index = 0; blink counter = 0; blink phase = 0 (visible); snapshot = 0:00, to=0.
  - hex_seg and hex_grid are all unlit (all 1s when SEG_ACTIVE_LOW=1).
- Refresh counter:
  - Counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the digit index advances mod 4 (3 wraps to 0).
- Snapshot:
  - minute, second and to are registered together on the cycle the index wraps 3→0. This prevents tearing within one scan frame.
  - Inputs are not sampled at any other time.
  - The first snapshot after reset occurs at the first 3→0 wrap; until then the snapshot reset values apply.
- Digit mapping (from snapshot):
  - idx3: blank.
  - idx2: minute value, with dp lit as the colon.
  - idx1: second/10.
  - idx0: second%10.
  - If the snapshot second > 59: idx1 and idx0 show dash (segment g only); minute is still shown.
- Output timing:
  - hex_seg and hex_grid are registered and reflect the digit index with one cycle of latency.
  - Exactly one grid bit is lit at a time, or none.
- Blink:
  - The blink counter runs only while snapshot to=1. It counts 0..BLINK_DIV-1, and the blink phase toggles at terminal count.
  - Phase 1: all grids unlit; phase 0: normal display of 0:00.
  - When snapshot to returns to 0: blink counter and phase clear in the same cycle.
- enable=0:
  - Grids unlit on the next cycle. Refresh counter and digit index keep running; blink counter and phase are held at 0.
  - Re-enable: display resumes at the current index with no restart.
- Simultaneous events: snapshot capture, index wrap and blink toggle may coincide. The new snapshot takes effect on the following output cycle.
- Reset mid-scan: immediate return to reset state; no partial-frame output.

Optional Feature:
- Macro: LOW_TIME_WARN_EN.
- Defined: when snapshot to=0, minute=0 and second<10, the dp on idx0 blinks using the blink counter and phase. Here the blink counter also runs during low time.
- Undefined: idx0 dp is always unlit, and the blink counter runs only on timeout.

Decomposition:
- Package chess_display_pkg holds:
  - Constants SEG_BLANK, SEG_DASH and SEG_DIGIT[0:9] (active-high, 7-bit).
  - typedef digit_idx_t (logic [1:0]).
  - typedef bcd_t (logic [3:0]).
- Polarity inversion for SEG_ACTIVE_LOW is applied only at the output register.
- Sub-module seg7_decode: combinational bcd_t plus a dash flag in, 7-bit pattern out.

Test Plan (REFRESH_DIV=4, BLINK_DIV=16, SEG_ACTIVE_LOW=1):
- Reset held then released, inputs 2:37 → all outputs 1s during reset. After the first wrap (16 cycles): grid sequence 1110, 1101, 1011, 0111 at 4 cycles each; seg patterns 7, 3, 2 (dp low), blank.
- Inputs change from 1:05 to 0:59 mid-frame (index 1) → current frame still shows 1:05; the next frame shows 0:59.
- second=62, minute=1 → idx1 and idx0 show dash (only seg g low); idx2 shows 1 with colon.
- to=1 with 0:00 → grids alternate between 16 cycles of scanning and 16 cycles all 1s. Drop to to 0 → normal scan with no blank gap after the next snapshot.
- enable=0 for 10 cycles → hex_grid=1111 from the next cycle. Re-assert → the lit digit matches the continued index.
- With LOW_TIME_WARN_EN, 0:07 → idx0 dp toggles every 16 cycles. Without the macro, idx0 dp stays 1.

Source files
------------

// File: rtl/chess_display_pkg.sv
// Shared types and active-high seven-segment patterns for the clock display.
// Segment bit order is {g,f,e,d,c,b,a}; the dp bit is added by the driver.
package chess_display_pkg;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage

// File: rtl/clock_display_driver_seg7_decode.sv
// Combinational BCD to active-high seven-segment decoder.
// The dash flag overrides the digit; codes above 9 decode to blank.
module seg7_decode
    import chess_display_pkg::*;
(
    input  bcd_t       bcd,
    input  logic       dash,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        if (dash) begin
            pattern = SEG_DASH;
        end else if (bcd <= 4'd9) begin
            pattern = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/clock_display_driver.sv
// Four-digit multiplexed M:SS display driver with timeout blink.
// Define LOW_TIME_WARN_EN to blink the rightmost dp while under ten seconds remain.
module clock_display_driver
    import chess_display_pkg::*;
#(
    parameter int REFRESH_DIV    = 100000,
    parameter int BLINK_DIV      = 50000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] minute,
    input  logic [5:0] second,
    input  logic       to,
    output logic [7:0] hex_seg,
    output logic [3:0] hex_grid
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [7:0] SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] GRID_OFF = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [RW-1:0] refresh_cnt_reg;
    digit_idx_t    idx_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          blink_phase_reg;
    logic [1:0]    snap_min_reg;
    logic [5:0]    snap_sec_reg;
    logic          snap_to_reg;
    logic [7:0]    hex_seg_reg;
    logic [3:0]    hex_grid_reg;

    logic          refresh_wrap;
    logic          frame_wrap;
    logic          low_time_cur;
    logic          low_time_next;
    logic          run_cur;
    logic          run_next;
    logic          to_fall;
    logic          sec_dash;
    bcd_t          sec_tens;
    bcd_t          sec_ones;
    bcd_t          digit_bcd [4];
    logic [3:0]    digit_dash;
    logic [6:0]    pattern [4];
    logic [3:0]    dp_vec;
    logic [3:0]    grid_onehot;
    logic [7:0]    seg_next;
    logic [3:0]    grid_next;

    assign refresh_wrap = (refresh_cnt_reg == RW'(REFRESH_DIV - 1));
    assign frame_wrap   = refresh_wrap && (idx_reg == 2'd3);

`ifdef LOW_TIME_WARN_EN
    assign low_time_cur  = !snap_to_reg && (snap_min_reg == 2'd0) && (snap_sec_reg < 6'd10);
    assign low_time_next = frame_wrap ? (!to && (minute == 2'd0) && (second < 6'd10))
                                      : low_time_cur;
`else
    assign low_time_cur  = 1'b0;
    assign low_time_next = 1'b0;
`endif

    // run_next looks at the snapshot as it will be after this edge, so a
    // capture that ends the blink condition clears the counter immediately.
    assign run_cur  = snap_to_reg || low_time_cur;
    assign run_next = (frame_wrap ? to : snap_to_reg) || low_time_next;
    assign to_fall  = frame_wrap && snap_to_reg && !to;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_cnt_reg <= '0;
            idx_reg         <= '0;
        end else if (refresh_wrap) begin
            refresh_cnt_reg <= '0;
            idx_reg         <= idx_reg + 2'd1;
        end else begin
            refresh_cnt_reg <= refresh_cnt_reg + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_min_reg <= '0;
            snap_sec_reg <= '0;
            snap_to_reg  <= 1'b0;
        end else if (frame_wrap) begin
            snap_min_reg <= minute;
            snap_sec_reg <= second;
            snap_to_reg  <= to;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (!enable || !run_next || to_fall) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (run_cur) begin
            if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BW'(1);
            end
        end
    end

    assign sec_dash  = (snap_sec_reg > 6'd59);
    assign sec_tens  = 4'(snap_sec_reg / 6'd10);
    assign sec_ones  = 4'(snap_sec_reg % 6'd10);

    assign digit_bcd[0] = sec_ones;
    assign digit_bcd[1] = sec_tens;
    assign digit_bcd[2] = {2'b00, snap_min_reg};
    assign digit_bcd[3] = 4'hF;
    assign digit_dash   = {1'b0, 1'b0, sec_dash, sec_dash};
    assign dp_vec       = {1'b0, 1'b1, 1'b0, low_time_cur && blink_phase_reg};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            seg7_decode u_dec (
                .bcd     (digit_bcd[gi]),
                .dash    (digit_dash[gi]),
                .pattern (pattern[gi])
            );
            assign grid_onehot[gi] = (idx_reg == digit_idx_t'(gi));
        end
    endgenerate

    always_comb begin
        seg_next  = {dp_vec[idx_reg], pattern[idx_reg]};
        grid_next = grid_onehot;
        if (!enable || (snap_to_reg && blink_phase_reg)) begin
            seg_next  = '0;
            grid_next = '0;
        end
    end

    // Polarity is applied only here; everything upstream is active-high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex_seg_reg  <= SEG_OFF;
            hex_grid_reg <= GRID_OFF;
        end else begin
            hex_seg_reg  <= SEG_ACTIVE_LOW ? ~seg_next : seg_next;
            hex_grid_reg <= SEG_ACTIVE_LOW ? ~grid_next : grid_next;
        end
    end

    assign hex_seg  = hex_seg_reg;
    assign hex_grid = hex_grid_reg;

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed bench for clock_display_driver with REFRESH_DIV=4, BLINK_DIV=16, active-low outputs.
// Edge counter k counts posedges since reset release; outputs are sampled 1 time unit after each edge.
module tb_clock_display_driver;

    typedef struct packed {
        logic [1:0]  minute;
        logic [5:0]  second;
        logic [31:0] segs;   // {idx3, idx2, idx1, idx0}
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] minute = 2'd0;
    logic [5:0] second = 6'd0;
    logic       to = 1'b0;
    logic [7:0] hex_seg;
    logic [3:0] hex_grid;

    int checks = 0;
    int errors = 0;
    int k = 0;

    vec_t       vecs [5];
    logic [3:0] grid_exp [4];
    logic [31:0] frame0_segs;
    logic [7:0] dp_warn_seg;

    always #5 clk = ~clk;

    clock_display_driver #(
        .REFRESH_DIV    (4),
        .BLINK_DIV      (16),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .minute   (minute),
        .second   (second),
        .to       (to),
        .hex_seg  (hex_seg),
        .hex_grid (hex_grid)
    );

    task automatic step();
        @(posedge clk);
        k++;
        #1;
    endtask

    task automatic go_to(input int n);
        while (k < n) step();
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
        end else begin
            $display("ok   %s k=%0d value=%h", name, k, act);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] g, input logic [7:0] s);
        chk({name, "_grid"}, {4'h0, hex_grid}, {4'h0, g});
        chk({name, "_seg"}, hex_seg, s);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1, "timeout");
    end

    initial begin
        grid_exp[0] = 4'b1110;
        grid_exp[1] = 4'b1101;
        grid_exp[2] = 4'b1011;
        grid_exp[3] = 4'b0111;
        frame0_segs = {8'hFF, 8'h40, 8'hC0, 8'hC0};
        vecs[0] = '{minute: 2'd2, second: 6'd37, segs: {8'hFF, 8'h24, 8'hB0, 8'hF8}};
        vecs[1] = '{minute: 2'd1, second: 6'd5,  segs: {8'hFF, 8'h79, 8'hC0, 8'h92}};
        vecs[2] = '{minute: 2'd0, second: 6'd59, segs: {8'hFF, 8'h40, 8'h92, 8'h90}};
        vecs[3] = '{minute: 2'd1, second: 6'd62, segs: {8'hFF, 8'h79, 8'hBF, 8'hBF}};
        vecs[4] = '{minute: 2'd3, second: 6'd0,  segs: {8'hFF, 8'h30, 8'hC0, 8'hC0}};
`ifdef LOW_TIME_WARN_EN
        dp_warn_seg = 8'h78;
`else
        dp_warn_seg = 8'hF8;
`endif

        // Reset held with 2:37 on the inputs
        minute = vecs[0].minute;
        second = vecs[0].second;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 4'hF, 8'hFF);
        reset = 1'b1;
        k = 0;

        // First frame still shows the 0:00 reset snapshot
        for (int d = 0; d < 4; d++) begin
            go_to(2 + 4 * d);
            chk_out("frame0", grid_exp[d], frame0_segs[8*d +: 8]);
        end

        // Each vector is shown in its own frame; the next one is applied mid-frame
        for (int i = 0; i < 5; i++) begin
            for (int d = 0; d < 4; d++) begin
                go_to(16 * (i + 1) + 2 + 4 * d);
                chk_out($sformatf("vec%0d_d%0d", i, d), grid_exp[d], vecs[i].segs[8*d +: 8]);
                if (d == 1 && i < 4) begin
                    minute = vecs[i + 1].minute;
                    second = vecs[i + 1].second;
                end
            end
        end

        // Timeout blink at 0:00, captured at k=96
        minute = 2'd0;
        second = 6'd0;
        to = 1'b1;
        go_to(100); chk_out("to_vis0", 4'b1110, 8'hC0);
        go_to(112); chk_out("to_vis1", 4'b0111, 8'hFF);
        go_to(113); chk_out("to_blank0", 4'hF, 8'hFF);
        go_to(128); chk_out("to_blank1", 4'hF, 8'hFF);
        go_to(129); chk_out("to_vis2", 4'b1110, 8'hC0);
        go_to(145); chk_out("to_blank2", 4'hF, 8'hFF);
        to = 1'b0;
        go_to(160); chk_out("to_blank3", 4'hF, 8'hFF);
        go_to(161); chk_out("to_clear0", 4'b1110, 8'hC0);
        go_to(165); chk_out("to_clear1", 4'b1101, 8'hC0);

        // Enable dropped for 10 cycles, then resumes on the running index
        go_to(170);
        enable = 1'b0;
        go_to(171); chk_out("dis0", 4'hF, 8'hFF);
        go_to(175); chk_out("dis1", 4'hF, 8'hFF);
        go_to(180);
        enable = 1'b1;
        go_to(181); chk_out("reen0", 4'b1101, 8'hC0);
        go_to(185); chk_out("reen1", 4'b1011, 8'h40);

        // 0:07 captured at k=192: idx0 dp behaviour depends on the build
        minute = 2'd0;
        second = 6'd7;
        go_to(194); chk_out("low0", 4'b1110, 8'hF8);
        go_to(198); chk_out("low_d1", 4'b1101, 8'hC0);
        go_to(210); chk_out("low1", 4'b1110, dp_warn_seg);
        go_to(226); chk_out("low2", 4'b1110, 8'hF8);

        // Reset asserted mid-scan acts immediately; snapshot returns to 0:00
        go_to(230);
        #2 reset = 1'b0;
        #1 chk_out("midreset", 4'hF, 8'hFF);
        #2 reset = 1'b1;
        k = 0;
        go_to(2); chk_out("post_reset0", 4'b1110, 8'hC0);
        go_to(6); chk_out("post_reset1", 4'b1101, 8'hC0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
